// File: rtl/csr_file_if.sv
// csr_file_if: bundle between the pipeline and the machine-mode CSR file.
//   master : pipeline side; drives the CSR instruction port, trap/interrupt/MRET
//            requests and the retire strobe; receives read data, illegal flag,
//            stall and the PC redirect.
//   slave  : CSR file side; the mirror image of master.
interface csr_file_if;
    logic [11:0] csr_addr;
    logic        csr_rd_en;
    logic        csr_wr_en;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] epc_in;
    logic        mret_req;
    logic        instr_retire;
    logic        ext_irq;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
        output trap_req, trap_cause, epc_in, mret_req, instr_retire, ext_irq,
        input  csr_rdata, csr_illegal, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  csr_addr, csr_rd_en, csr_wr_en, csr_wdata,
        input  trap_req, trap_cause, epc_in, mret_req, instr_retire, ext_irq,
        output csr_rdata, csr_illegal, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/csr_file_ctrl.sv
// csr_file_ctrl: machine-mode CSR register file and trap sequencer.
// Holds mstatus (MIE/MPIE), mie (MEIE), mtvec, mscratch, mepc, mcause and the
// 64-bit mcycle/minstret counters; serves the CSR instruction port; arbitrates
// it against synchronous traps, the external interrupt and MRET; sequences
// trap entry/return with a pipeline stall and a one-cycle PC redirect.
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : csr_file_if.slave (CSR port, trap/irq/mret requests, stall, redirect)
module csr_file_ctrl #(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        TRAP_SAVE,
        TRAP_JUMP,
        MRET_JUMP
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH= 12'hB82;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

    state_t      state;
    logic        mie;
    logic        mpie;
    logic        meie;
    logic [31:0] mtvec;      // low two bits always held at zero
    logic [31:0] mscratch;
    logic [31:0] mepc;       // low two bits always held at zero
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        redir_valid;
    logic [31:0] redir_pc;

    logic [31:0] rdata;
    logic        implemented;
    logic        read_only;
    logic        irq_take;
    logic        write_ok;

    // Address decode and read mux.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        rdata       = 32'h0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (bus.csr_addr)
            ADDR_MSTATUS:   rdata = {24'h0, mpie, 3'b000, mie, 3'b000};
            ADDR_MIE:       rdata = {20'h0, meie, 11'h0};
            ADDR_MTVEC:     rdata = mtvec;
            ADDR_MSCRATCH:  rdata = mscratch;
            ADDR_MEPC:      rdata = mepc;
            ADDR_MCAUSE:    rdata = mcause;
            ADDR_MIP: begin
                rdata     = {20'h0, bus.ext_irq, 11'h0};
                read_only = 1'b1;
            end
            ADDR_MCYCLE:    rdata = mcycle[31:0];
            ADDR_MCYCLEH:   rdata = mcycle[63:32];
            ADDR_MINSTRET:  rdata = minstret[31:0];
            ADDR_MINSTRETH: rdata = minstret[63:32];
            ADDR_MHARTID: begin
                rdata     = HART_ID;
                read_only = 1'b1;
            end
            default:        implemented = 1'b0;
        endcase
    end

    assign irq_take = mie & meie & bus.ext_irq;
    // Illegal writes never reach the register update below.
    assign write_ok = bus.csr_wr_en & implemented & ~read_only;

    assign bus.csr_rdata      = rdata;
    assign bus.csr_illegal    = ((bus.csr_rd_en | bus.csr_wr_en) & ~implemented)
                              | (bus.csr_wr_en & read_only);
    assign bus.stall          = (state != IDLE);
    assign bus.redirect_valid = redir_valid;
    assign bus.redirect_pc    = redir_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            meie        <= 1'b0;
            mtvec       <= {RESET_VEC[31:2], 2'b00};
            mscratch    <= 32'h0;
            mepc        <= 32'h0;
            mcause      <= 32'h0;
            mcycle      <= 64'h0;
            minstret    <= 64'h0;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments only, so every register samples
            // pre-edge values; later assignments below override these defaults.
            redir_valid <= 1'b0;
            mcycle      <= mcycle + 64'd1;
            if (bus.instr_retire) begin
                minstret <= minstret + 64'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.trap_req || irq_take) begin
                        mepc   <= {bus.epc_in[31:2], 2'b00};
                        mcause <= bus.trap_req ? bus.trap_cause : IRQ_CAUSE;
                        mpie   <= mie;
                        mie    <= 1'b0;
                        state  <= TRAP_SAVE;
                    end else if (bus.mret_req) begin
                        // Redirect is registered, so it appears in MRET_JUMP.
                        redir_valid <= 1'b1;
                        redir_pc    <= mepc;
                        state       <= MRET_JUMP;
                    end else if (write_ok) begin
                        // A counter write replaces that cycle's increment.
                        case (bus.csr_addr)
                            ADDR_MSTATUS: begin
                                mie  <= bus.csr_wdata[3];
                                mpie <= bus.csr_wdata[7];
                            end
                            ADDR_MIE:       meie     <= bus.csr_wdata[11];
                            ADDR_MTVEC:     mtvec    <= {bus.csr_wdata[31:2], 2'b00};
                            ADDR_MSCRATCH:  mscratch <= bus.csr_wdata;
                            ADDR_MEPC:      mepc     <= {bus.csr_wdata[31:2], 2'b00};
                            ADDR_MCAUSE:    mcause   <= bus.csr_wdata;
                            ADDR_MCYCLE:    mcycle   <= {mcycle[63:32], bus.csr_wdata};
                            ADDR_MCYCLEH:   mcycle   <= {bus.csr_wdata, mcycle[31:0]};
                            ADDR_MINSTRET:  minstret <= {minstret[63:32], bus.csr_wdata};
                            ADDR_MINSTRETH: minstret <= {bus.csr_wdata, minstret[31:0]};
                            default: ;
                        endcase
                    end
                end
                TRAP_SAVE: begin
                    redir_valid <= 1'b1;
                    redir_pc    <= mtvec;
                    state       <= TRAP_JUMP;
                end
                TRAP_JUMP: begin
                    state <= IDLE;
                end
                MRET_JUMP: begin
                    mie   <= mpie;
                    mpie  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_file_ctrl.sv
// tb_csr_file_ctrl: directed bench for csr_file_ctrl. A cycle-indexed model of
// the CSR file (plain variables, a busy window and a scheduled redirect) is
// compared with the DUT every cycle; directed checks pin literal values.
module tb_csr_file_ctrl;
    localparam logic [31:0] HART = 32'd5;
    localparam logic [31:0] RVEC = 32'h0000_0203;

    logic clk = 1'b0;
    logic rst;
    logic started = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    csr_file_if bus ();

    csr_file_ctrl #(.HART_ID(HART), .RESET_VEC(RVEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_mie, m_mpie, m_meie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;
    int          m_cyc, m_busy_end, m_redir_cyc;
    logic [31:0] m_redir_pc;
    logic        m_mret_pend;

    function automatic logic m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14};
    endfunction

    function automatic logic m_ro(input logic [11:0] a);
        return (a == 12'h344) || (a == 12'hF14);
    endfunction

    function automatic logic [31:0] m_rdata(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_meie ? 32'h800 : 32'h0;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return bus.ext_irq ? 32'h800 : 32'h0;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            12'hF14: return HART;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mie <= 1'b0; m_mpie <= 1'b0; m_meie <= 1'b0;
            m_mtvec <= RVEC & ~32'h3;
            m_mscratch <= 32'h0; m_mepc <= 32'h0; m_mcause <= 32'h0;
            m_mcycle <= 64'h0; m_minstret <= 64'h0;
            m_cyc <= 0; m_busy_end <= 0; m_redir_cyc <= -1;
            m_redir_pc <= 32'h0; m_mret_pend <= 1'b0;
        end else begin
            m_cyc      <= m_cyc + 1;
            m_mcycle   <= m_mcycle + 64'd1;
            m_minstret <= m_minstret + {63'd0, bus.instr_retire};
            if (m_cyc >= m_busy_end) begin
                if (bus.trap_req || (m_mie && m_meie && bus.ext_irq)) begin
                    m_mepc      <= bus.epc_in & ~32'h3;
                    m_mcause    <= bus.trap_req ? bus.trap_cause : 32'h8000_000B;
                    m_mpie      <= m_mie;
                    m_mie       <= 1'b0;
                    m_busy_end  <= m_cyc + 3;
                    m_redir_cyc <= m_cyc + 2;
                    m_redir_pc  <= m_mtvec;
                end else if (bus.mret_req) begin
                    m_busy_end  <= m_cyc + 2;
                    m_redir_cyc <= m_cyc + 1;
                    m_redir_pc  <= m_mepc;
                    m_mret_pend <= 1'b1;
                end else if (bus.csr_wr_en) begin
                    case (bus.csr_addr)
                        12'h300: begin m_mie <= bus.csr_wdata[3]; m_mpie <= bus.csr_wdata[7]; end
                        12'h304: m_meie     <= bus.csr_wdata[11];
                        12'h305: m_mtvec    <= bus.csr_wdata & ~32'h3;
                        12'h340: m_mscratch <= bus.csr_wdata;
                        12'h341: m_mepc     <= bus.csr_wdata & ~32'h3;
                        12'h342: m_mcause   <= bus.csr_wdata;
                        12'hB00: m_mcycle   <= {m_mcycle[63:32], bus.csr_wdata};
                        12'hB80: m_mcycle   <= {bus.csr_wdata, m_mcycle[31:0]};
                        12'hB02: m_minstret <= {m_minstret[63:32], bus.csr_wdata};
                        12'hB82: m_minstret <= {bus.csr_wdata, m_minstret[31:0]};
                        default: ;
                    endcase
                end
            end
            if (m_mret_pend && (m_cyc == m_redir_cyc)) begin
                m_mie       <= m_mpie;
                m_mpie      <= 1'b1;
                m_mret_pend <= 1'b0;
            end
        end
    end

    // Per-cycle comparison, late in the cycle with inputs and outputs settled.
    always @(negedge clk) begin
        #4;
        if (started && !rst) begin
            check("cmp_rdata", bus.csr_rdata, m_rdata(bus.csr_addr));
            check1("cmp_illegal", bus.csr_illegal,
                   ((bus.csr_rd_en | bus.csr_wr_en) & ~m_impl(bus.csr_addr))
                   | (bus.csr_wr_en & m_ro(bus.csr_addr)));
            check1("cmp_stall", bus.stall, m_cyc < m_busy_end);
            check1("cmp_redirect_valid", bus.redirect_valid, m_cyc == m_redir_cyc);
            if (m_cyc == m_redir_cyc)
                check("cmp_redirect_pc", bus.redirect_pc, m_redir_pc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        bus.csr_addr = 12'h0; bus.csr_rd_en = 1'b0; bus.csr_wr_en = 1'b0;
        bus.csr_wdata = 32'h0; bus.trap_req = 1'b0; bus.trap_cause = 32'h0;
        bus.epc_in = 32'h0; bus.mret_req = 1'b0; bus.instr_retire = 1'b0;
        bus.ext_irq = 1'b0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_addr = a; bus.csr_wr_en = 1'b1; bus.csr_wdata = d;
        @(negedge clk);
        bus.csr_wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_addr = a; bus.csr_rd_en = 1'b1;
        #1 check(name, bus.csr_rdata, exp);
        @(negedge clk);
        bus.csr_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        bus.csr_addr = 12'h305;
        repeat (2) @(negedge clk);
        #1;
        check1("rst_stall", bus.stall, 1'b0);
        check1("rst_redirect_valid", bus.redirect_valid, 1'b0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        check("rst_mtvec", bus.csr_rdata, 32'h0000_0200);
        @(negedge clk);
        rst = 1'b0;
        started = 1'b1;

        // 1: reset values and mcycle start
        rd_chk("mcycle_0", 12'hB00, 32'd0);
        rd_chk("mcycle_1", 12'hB00, 32'd1);
        rd_chk("mcycle_2", 12'hB00, 32'd2);
        rd_chk("mtvec_reset", 12'h305, 32'h0000_0200);
        rd_chk("mhartid", 12'hF14, HART);

        // 2: field masking and illegal accesses
        wr(12'h300, 32'hFFFF_FFFF);
        rd_chk("mstatus_mask", 12'h300, 32'h0000_0088);
        wr(12'h300, 32'h0);
        wr(12'h305, 32'h0000_1003);
        rd_chk("mtvec_mask", 12'h305, 32'h0000_1000);
        bus.csr_addr = 12'h7C0; bus.csr_rd_en = 1'b1;
        #1 check1("illegal_rd", bus.csr_illegal, 1'b1);
        check("illegal_rdata", bus.csr_rdata, 32'h0);
        @(negedge clk);
        bus.csr_rd_en = 1'b0;
        bus.csr_addr = 12'h344; bus.csr_wr_en = 1'b1; bus.csr_wdata = 32'hFFFF_FFFF;
        #1 check1("illegal_wr_mip", bus.csr_illegal, 1'b1);
        @(negedge clk);
        bus.csr_wr_en = 1'b0;
        rd_chk("mip_unchanged", 12'h344, 32'h0);

        // 3: synchronous trap
        wr(12'h305, 32'h0000_0100);
        bus.trap_req = 1'b1; bus.trap_cause = 32'd2; bus.epc_in = 32'h44;
        @(negedge clk);
        clear_in();
        #1 check1("t3_stall_c1", bus.stall, 1'b1);
        check1("t3_rv_c1", bus.redirect_valid, 1'b0);
        @(negedge clk);
        #1 check1("t3_stall_c2", bus.stall, 1'b1);
        check1("t3_rv_c2", bus.redirect_valid, 1'b1);
        check("t3_pc", bus.redirect_pc, 32'h0000_0100);
        @(negedge clk);
        #1 check1("t3_stall_done", bus.stall, 1'b0);
        @(negedge clk);
        rd_chk("t3_mepc", 12'h341, 32'h44);
        rd_chk("t3_mcause", 12'h342, 32'd2);

        // 4: external interrupt then MRET
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        bus.ext_irq = 1'b1; bus.epc_in = 32'h207;
        @(negedge clk);
        clear_in();
        #1 check1("t4_stall", bus.stall, 1'b1);
        @(negedge clk);
        #1 check("t4_pc", bus.redirect_pc, 32'h0000_0100);
        @(negedge clk);
        rd_chk("t4_mcause", 12'h342, 32'h8000_000B);
        rd_chk("t4_mstatus_trap", 12'h300, 32'h0000_0080);
        rd_chk("t4_mepc", 12'h341, 32'h0000_0204);
        bus.mret_req = 1'b1;
        @(negedge clk);
        bus.mret_req = 1'b0;
        #1 check1("t4_mret_rv", bus.redirect_valid, 1'b1);
        check("t4_mret_pc", bus.redirect_pc, 32'h0000_0204);
        @(negedge clk);
        #1 check1("t4_mret_stall_done", bus.stall, 1'b0);
        rd_chk("t4_mstatus_ret", 12'h300, 32'h0000_0088);

        // 5: trap beats MRET and a CSR write in the same cycle
        wr(12'h340, 32'h1111_2222);
        bus.trap_req = 1'b1; bus.trap_cause = 32'd7; bus.epc_in = 32'h80;
        bus.mret_req = 1'b1;
        bus.csr_addr = 12'h340; bus.csr_wr_en = 1'b1; bus.csr_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_in();
        #1 check1("t5_rv_c1", bus.redirect_valid, 1'b0);
        @(negedge clk);
        #1 check("t5_pc", bus.redirect_pc, 32'h0000_0100);
        @(negedge clk);
        #1 check1("t5_no_mret_rv", bus.redirect_valid, 1'b0);
        rd_chk("t5_mscratch", 12'h340, 32'h1111_2222);
        rd_chk("t5_mcause", 12'h342, 32'd7);
        rd_chk("t5_mstatus", 12'h300, 32'h0000_0080);

        // 6: counter carry, full wrap, write-wins and retire gating
        wr(12'hB80, 32'd7);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh_carry", 12'hB80, 32'd8);
        rd_chk("mcycle_lo_wrap", 12'hB00, 32'd1);
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd_chk("mcycleh_max", 12'hB80, 32'hFFFF_FFFF);
        rd_chk("mcycleh_wrap", 12'hB80, 32'h0);
        bus.instr_retire = 1'b1;
        wr(12'hB02, 32'hFFFF_FFFF);
        rd_chk("minstret_lo_max", 12'hB02, 32'hFFFF_FFFF);
        rd_chk("minstreth_carry", 12'hB82, 32'd1);
        bus.instr_retire = 1'b0;
        rd_chk("minstret_hold_a", 12'hB02, 32'd1);
        rd_chk("minstret_hold_b", 12'hB02, 32'd1);

        // reset asserted in TRAP_SAVE aborts the sequence
        bus.trap_req = 1'b1; bus.trap_cause = 32'd3; bus.epc_in = 32'h10;
        @(negedge clk);
        clear_in();
        #1 check1("abort_stall_before", bus.stall, 1'b1);
        #1 rst = 1'b1;
        #1 check1("abort_stall", bus.stall, 1'b0);
        check1("abort_rv", bus.redirect_valid, 1'b0);
        check("abort_pc", bus.redirect_pc, 32'h0);
        @(negedge clk);
        #1 check1("abort_rv_held", bus.redirect_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("abort_mcycle", 12'hB00, 32'd0);
        rd_chk("abort_mtvec", 12'h305, 32'h0000_0200);
        rd_chk("abort_mstatus", 12'h300, 32'h0);
        rd_chk("abort_mie", 12'h304, 32'h0);
        rd_chk("abort_mscratch", 12'h340, 32'h0);
        rd_chk("abort_mepc", 12'h341, 32'h0);
        rd_chk("abort_mcause", 12'h342, 32'h0);
        rd_chk("abort_minstret", 12'hB02, 32'h0);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csr_file_ctrl.md
Name: csr_file_ctrl

Overview:
Machine-mode CSR register file and trap sequencer for the core.
- Holds mstatus, mie, mtvec, mscratch, mepc, mcause, mcycle and minstret.
- Serves the CSR-instruction port: a read/write pair plus the already-computed write value from the CSR ALU.
- Arbitrates that port against synchronous traps, the external interrupt and MRET.
- Sequences trap entry and return, stalls the pipeline while it does so, and issues the PC redirect.

Parameters:
HART_ID, 0, value returned by mhartid (0xF14)
RESET_VEC, 32'h0000_0000, reset value of mtvec (bits [1:0] forced 0)

Ports:
clk  input  1  core clock
rst  input  1  reset; asynchronous, active-high
csr_addr  input  12  CSR address of current CSR instruction
csr_rd_en  input  1  CSR read request
csr_wr_en  input  1  CSR write request
csr_wdata  input  32  value to write (ALU result)
csr_rdata  output  32  combinational read data
csr_illegal  output  1  combinational; access to unimplemented CSR, or write to read-only CSR
trap_req  input  1  synchronous exception from pipeline
trap_cause  input  32  mcause value for trap_req
epc_in  input  32  PC to save in mepc (faulting PC, or next PC for an interrupt)
mret_req  input  1  MRET executing
instr_retire  input  1  one instruction retired this cycle
ext_irq  input  1  level external interrupt
stall  output  1  pipeline hold
redirect_valid  output  1  one-cycle PC redirect strobe
redirect_pc  output  32  redirect target

Behaviour:
- Reset (async): all CSRs 0 except mtvec=RESET_VEC; state IDLE; stall, redirect_valid and redirect_pc = 0. Asserting rst mid-sequence aborts it with no partial redirect.
- Address map:
  - mstatus 0x300: only bit3 MIE and bit7 MPIE are stored; other bits read 0.
  - mie 0x304: only bit11 MEIE is stored.
  - mtvec 0x305: bits [1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only; bit11 = ext_irq.
  - mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82: 64-bit counters.
  - mhartid 0xF14: read-only, returns HART_ID.
  - Any other address: illegal, rdata 0.
- csr_illegal = (rd_en|wr_en) & unimplemented, or wr_en to 0x344/0xF14. An illegal write changes no state.
- CSR writes commit at the clock edge, only in IDLE and only with no trap, interrupt or MRET accepted that cycle. A dropped write is not retried.
- Counters:
  - mcycle increments every cycle; minstret increments when instr_retire=1.
  - A CSR write to either half wins over that cycle's increment.
  - Low half 0xFFFF_FFFF incrementing carries into the high half; full wrap goes to 0.
- Interrupt condition irq_take = MIE & MEIE & ext_irq.
- FSM states: IDLE, TRAP_SAVE, TRAP_JUMP, MRET_JUMP.
- IDLE priority: trap_req > irq_take > mret_req > CSR write.
  - trap_req or irq_take -> TRAP_SAVE. Captures mepc = epc_in & ~3 and mcause = trap_cause (or 0x8000_000B for the interrupt) at this edge. Also MPIE <= MIE, MIE <= 0.
  - mret_req -> MRET_JUMP.
- TRAP_SAVE -> TRAP_JUMP: unconditional, 1 cycle.
- TRAP_JUMP: redirect_valid=1, redirect_pc = mtvec & ~3; -> IDLE.
- MRET_JUMP: redirect_valid=1, redirect_pc = mepc; at the edge MIE <= MPIE, MPIE <= 1; -> IDLE.
- Latency: trap/interrupt redirect on the 2nd cycle after the request; MRET redirect on the 1st.
- stall = 1 whenever state != IDLE, combinational from state.
- Requests arriving while not in IDLE are ignored; the pipeline holds them under stall.
- csr_rdata always reflects current register contents, including in non-IDLE states.

Test Plan:
1. Reset -> read 0x305 returns RESET_VEC & ~3; read 0xF14 returns HART_ID; mcycle reads 0 on the first cycle after reset release, then increments by 1 per cycle.
2. Write 0x300=0xFFFF_FFFF -> reads 0x0000_0088; write 0x305=0x1003 -> reads 0x1000; read 0x7C0 -> csr_illegal=1, rdata 0; write 0x344 -> csr_illegal=1, mip unchanged.
3. mtvec=0x100, trap_req with cause 2, epc_in=0x44 -> mepc=0x44, mcause=2, stall high 2 cycles, redirect_valid with pc 0x100 on 2nd cycle.
4. MIE=1, MEIE=1, ext_irq=1 -> mcause=0x8000_000B, MIE=0, MPIE=1; then mret_req -> redirect to mepc next cycle, MIE=1, MPIE=1.
5. trap_req, mret_req and a CSR write to 0x340 in the same cycle -> trap taken, mscratch unchanged, MRET ignored.
6. mcycle low half = 0xFFFF_FFFF -> next reads low 0, mcycleh +1. Assert rst during TRAP_SAVE -> no redirect, state IDLE, all CSRs at reset values.
